// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Purpose  : Shared types, default parameters and helpers for the
//            round-robin register write arbiter (reg_write_arbiter).
// Contents : arb_state_t   - FSM state encoding (IDLE / HOLD)
//            DEF_*         - default NUM_REQ / WIDTH / HOLD_CYCLES
//            hold_cnt_width- width of the hold down-counter
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_WIDTH       = 8;
   localparam int DEF_HOLD_CYCLES = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_t;

   // The hold counter is loaded with HOLD_CYCLES-1 and counts down to 1,
   // so it only has to represent values up to HOLD_CYCLES-1.  A one-bit
   // counter is kept even when HOLD_CYCLES==1 so the port of the register
   // never collapses to zero width.
   function automatic int hold_cnt_width(input int hold);
      if (hold < 2) begin
         return 1;
      end
      return $clog2(hold);
   endfunction

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority selector.  Returns the first
//            set request bit scanning i_ptr, i_ptr+1, ..., NUM_REQ-1, 0, ...,
//            i_ptr-1.
// Ports    : i_req       [NUM_REQ] request vector
//            i_ptr       [IDXW]    index holding highest priority
//            o_winner    [IDXW]    selected index (0 when nothing requests)
//            o_any_valid           at least one request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDXW    = $clog2(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDXW-1:0]    i_ptr,
   output logic [IDXW-1:0]    o_winner,
   output logic               o_any_valid
);

   int w_idx;

   // Scan from the farthest position back to i_ptr itself: the last hit
   // assigned is the one nearest to the pointer, which gives the required
   // priority without needing an early loop exit.
   always_comb begin
      o_winner    = '0;
      o_any_valid = 1'b0;
      w_idx       = 0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         w_idx = int'(i_ptr) + off;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         if (i_req[w_idx[IDXW-1:0]]) begin
            o_winner    = w_idx[IDXW-1:0];
            o_any_valid = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin write arbiter sharing one WIDTH-bit register among
//            NUM_REQ requesters.  One requester is granted per arbitration,
//            its data is captured into the register, and the block then
//            holds for HOLD_CYCLES-1 edges before arbitrating again.
// Ports    : clk        rising-edge clock
//            reset_n    synchronous active-low reset
//            req        [NUM_REQ]        level-sensitive write requests
//            d_in       [NUM_REQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//            gnt        [NUM_REQ]        one-hot, one-cycle grant pulse
//            q          [WIDTH]          shared register contents
//            q_valid                     sticky, set by first write
//            q_owner    [IDXW]           index of last requester written
//            busy                        high in the cycles after a grant
//                                        while further grants are blocked
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   d_in,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]           q,
   output logic                       q_valid,
   output logic [$clog2(NUM_REQ)-1:0] q_owner,
   output logic                       busy
);

   localparam int IDXW = $clog2(NUM_REQ);
   localparam int CNTW = hold_cnt_width(HOLD_CYCLES);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   arb_state_t        r_state;
   logic [CNTW-1:0]   r_cnt;
   logic [IDXW-1:0]   r_ptr;
   logic [NUM_REQ-1:0] r_gnt;
   logic [WIDTH-1:0]  r_q;
   logic              r_valid;
   logic [IDXW-1:0]   r_owner;
   logic              r_busy;

   // ------------------------------------------------------------------
   // Arbitration datapath
   // ------------------------------------------------------------------
   logic [NUM_REQ-1:0] w_eff_req;
   logic [IDXW-1:0]    w_winner;
   logic               w_any;
   logic [WIDTH-1:0]   w_win_data;
   logic [IDXW-1:0]    w_ptr_next;
   logic [NUM_REQ-1:0] w_win_onehot;

   // A requester whose grant is currently visible has not yet had the
   // chance to drop its request; masking it prevents a double write of the
   // same (stale) data when back-to-back grants are possible.
   assign w_eff_req = req & ~r_gnt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW)
   ) u_rr_pick (
      .i_req       (w_eff_req),
      .i_ptr       (r_ptr),
      .o_winner    (w_winner),
      .o_any_valid (w_any)
   );

   assign w_win_data   = d_in[int'(w_winner)*WIDTH +: WIDTH];
   assign w_win_onehot = NUM_REQ'(1) << w_winner;

   // Explicit wrap keeps the pointer correct for non-power-of-two NUM_REQ.
   assign w_ptr_next = (w_winner == IDXW'(NUM_REQ - 1)) ? '0
                                                        : w_winner + IDXW'(1);

   // ------------------------------------------------------------------
   // FSM, hold counter, pointer and shared register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_q     <= '0;
         r_valid <= 1'b0;
         r_owner <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_gnt  <= '0;
         // busy trails the state by one cycle so that it covers the
         // cycles after the grant cycle, not the grant cycle itself.
         r_busy <= (r_state == ST_HOLD);

         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_win_onehot;
                  r_q     <= w_win_data;
                  r_owner <= w_winner;
                  r_valid <= 1'b1;
                  r_ptr   <= w_ptr_next;
                  if (HOLD_CYCLES > 1) begin
                     r_state <= ST_HOLD;
                     r_cnt   <= CNTW'(HOLD_CYCLES - 1);
                  end
               end
            end

            ST_HOLD: begin
               r_cnt <= r_cnt - CNTW'(1);
               if (r_cnt == CNTW'(1)) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign q       = r_q;
   assign q_valid = r_valid;
   assign q_owner = r_owner;
   assign busy    = r_busy;

endmodule : reg_write_arbiter
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Self-checking bench for reg_write_arbiter.  Two instances share
//            the stimulus: HOLD_CYCLES=2 (main) and HOLD_CYCLES=1.  A
//            timestamp-based model predicts every output each cycle, and
//            directed literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [31:0] d_in;

   logic [3:0]  gnt,  gnt1;
   logic [7:0]  q,    q1;
   logic        q_valid, q_valid1;
   logic [1:0]  q_owner, q_owner1;
   logic        busy, busy1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reg_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .d_in(d_in),
      .gnt(gnt), .q(q), .q_valid(q_valid), .q_owner(q_owner), .busy(busy)
   );

   reg_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .req(req), .d_in(d_in),
      .gnt(gnt1), .q(q1), .q_valid(q_valid1), .q_owner(q_owner1), .busy(busy1)
   );

   // ------------------------------------------------------------------
   // Model: remembers the edge number of the last grant; a new grant is
   // allowed once at least h edges have elapsed since it.
   // ------------------------------------------------------------------
   typedef struct {
      int         en;
      int         last;
      bit         has;
      logic [1:0] ptr;
      logic [3:0] gnt;
      logic [7:0] q;
      logic [1:0] owner;
      bit         valid;
      bit         busy;
   } m_t;

   function automatic m_t step(input m_t s, input logic rn, input logic [3:0] r,
                               input logic [31:0] din, input int h);
      m_t n;
      logic [3:0] eff;
      int win;
      int age;
      n     = s;
      n.en  = s.en + 1;
      n.gnt = 4'b0000;
      if (!rn) begin
         n.has = 0; n.ptr = 2'd0; n.q = 8'h00; n.owner = 2'd0;
         n.valid = 0; n.busy = 0;
         return n;
      end
      eff = r & ~s.gnt;
      win = -1;
      if (!s.has || (n.en - s.last) >= h) begin
         for (int k = 0; k < 4; k++) begin
            if (win < 0 && eff[(int'(s.ptr) + k) % 4]) win = (int'(s.ptr) + k) % 4;
         end
      end
      if (win >= 0) begin
         n.gnt   = 4'(1 << win);
         n.q     = din[win*8 +: 8];
         n.owner = 2'(win);
         n.valid = 1;
         n.ptr   = 2'((win + 1) % 4);
         n.has   = 1;
         n.last  = n.en;
      end
      age    = n.en - n.last;
      n.busy = n.has && (age >= 1) && (age <= h - 1);
      return n;
   endfunction

   m_t m2 = '{default: 0};
   m_t m1 = '{default: 0};
   bit m_live = 0;

   always @(posedge clk) begin
      m2 <= step(m2, reset_n, req, d_in, 2);
      m1 <= step(m1, reset_n, req, d_in, 1);
      if (!reset_n) m_live <= 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle model comparison, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("m2.gnt",   gnt,     m2.gnt);
         chk("m2.q",     q,       m2.q);
         chk("m2.valid", q_valid, m2.valid);
         chk("m2.owner", q_owner, m2.owner);
         chk("m2.busy",  busy,    m2.busy);
         chk("m1.gnt",   gnt1,    m1.gnt);
         chk("m1.q",     q1,      m1.q);
         chk("m1.valid", q_valid1, m1.valid);
         chk("m1.owner", q_owner1, m1.owner);
         chk("m1.busy",  busy1,   m1.busy);
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus with literal expectations (inputs change on the
   // falling edge only).
   // ------------------------------------------------------------------
   initial begin
      reset_n = 1'b0;
      req     = 4'b1111;
      d_in    = {8'h13, 8'h12, 8'h11, 8'h10};

      // Reset held for two edges with all requests active.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst.gnt",   gnt,     32'h0);
         chk("rst.q",     q,       32'h0);
         chk("rst.valid", q_valid, 32'h0);
         chk("rst.busy",  busy,    32'h0);
      end
      reset_n = 1'b1;

      // Full contention: order 0,1,2,3,0 spaced by two edges.
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk("cont.gnt",   gnt,     32'(1 << (j % 4)));
         chk("cont.q",     q,       32'h10 + 32'(j % 4));
         chk("cont.owner", q_owner, 32'(j % 4));
         chk("cont.valid", q_valid, 32'h1);
         @(negedge clk);
         chk("cont.hold_gnt",  gnt,  32'h0);
         chk("cont.hold_busy", busy, 32'h1);
      end

      // Single requester 2 with data A5.
      req  = 4'b0100;
      d_in = {8'h13, 8'hA5, 8'h11, 8'h10};
      @(negedge clk);
      chk("single.gnt",   gnt,     32'h4);
      chk("single.q",     q,       32'hA5);
      chk("single.owner", q_owner, 32'h2);
      chk("single.valid", q_valid, 32'h1);
      chk("single.busy0", busy,    32'h0);
      req = 4'b0000;
      @(negedge clk);
      chk("single.busy1", busy, 32'h1);
      chk("single.gnt0",  gnt,  32'h0);

      // Reset during the busy cycle.
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst.busy",  busy,    32'h0);
      chk("midrst.q",     q,       32'h0);
      chk("midrst.valid", q_valid, 32'h0);
      chk("midrst.gnt",   gnt,     32'h0);
      req     = 4'b1111;
      reset_n = 1'b1;
      d_in    = {8'h13, 8'h12, 8'h11, 8'h10};
      @(negedge clk);
      chk("midrst.gnt0",  gnt,  32'h1);
      chk("midrst.gnt1",  gnt1, 32'h1);

      // Wrap and skip: bring ptr to 3, then request 0 and 1.
      req = 4'b0100;
      @(negedge clk);
      @(negedge clk);
      chk("wrap.gnt2", gnt, 32'h4);
      req = 4'b0011;
      @(negedge clk);
      @(negedge clk);
      chk("wrap.gnt0", gnt, 32'h1);
      chk("wrap.q0",   q,   32'h10);
      req = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      chk("wrap.gnt1",   gnt,     32'h2);
      chk("wrap.owner1", q_owner, 32'h1);
      chk("wrap.q1",     q,       32'h11);
      // ptr must now be 2: with 0,1,3 requesting, 3 wins.
      req = 4'b1011;
      @(negedge clk);
      @(negedge clk);
      chk("wrap.ptr2", gnt, 32'h8);
      chk("wrap.q3",   q,   32'h13);

      // HOLD_CYCLES=1 instance: alternating grants from a fresh reset.
      req     = 4'b0000;
      reset_n = 1'b0;
      @(negedge clk);
      req     = 4'b0011;
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("h1.alt", gnt1, (k % 2 == 0) ? 32'h1 : 32'h2);
      end
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_reg_write_arbiter
`default_nettype wire
